// File: rtl/mux_two_arbiter_if.sv
// Request/grant and datapath bundle between two requesters and the mux arbiter.
// The master modport is the requester side. The slave modport is the arbiter.
interface mux_two_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             select;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output req_a, req_b, a, b,
    input  select, grant_a, grant_b, out, out_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output select, grant_a, grant_b, out, out_valid
  );
endinterface

// File: rtl/mux_two_arbiter.sv
// Round-robin arbiter that owns the select line of a shared 2:1 mux.
// It limits how long one side may hold the grant, and registers the muxed data.
module mux_two_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_two_arbiter_if.slave   bus,
  output logic [1:0]         dbg_state
);
  // Handshake: a requester holds req high, with its data stable, for as long as it
  // sees its grant. The grant is registered and follows req by one cycle. A request
  // is dropped by lowering req. out_valid marks out, which captured the granted
  // input at the edge that ended the grant cycle.
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             sel_q;
  logic             ga_q;
  logic             gb_q;
  logic [WIDTH-1:0] out_q;
  logic             ov_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) nxt = last ? GRANT_A : GRANT_B;
        else if (bus.req_a)         nxt = GRANT_A;
        else if (bus.req_b)         nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!bus.req_a)                        nxt = bus.req_b ? GRANT_B : IDLE;
        else if (bus.req_b && cnt == HOLD_LAST) nxt = GRANT_B;
      end
      GRANT_B: begin
        if (!bus.req_b)                        nxt = bus.req_a ? GRANT_A : IDLE;
        else if (bus.req_a && cnt == HOLD_LAST) nxt = GRANT_A;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      sel_q <= 1'b0;
      ga_q  <= 1'b0;
      gb_q  <= 1'b0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      out_q <= sel_q ? bus.b : bus.a;
      ov_q  <= ga_q | gb_q;
      state <= nxt;
      ga_q  <= (nxt == GRANT_A);
      gb_q  <= (nxt == GRANT_B);
      // A new owner restarts its hold count. A continuing owner counts up and saturates.
      if (nxt != IDLE && nxt != state) begin
        cnt  <= '0;
        last <= (nxt == GRANT_B);
      end else if (nxt != IDLE && cnt != HOLD_LAST) begin
        cnt <= cnt + 1'b1;
      end
      if (nxt == GRANT_A)      sel_q <= 1'b0;
      else if (nxt == GRANT_B) sel_q <= 1'b1;
    end
  end

  assign bus.select    = sel_q;
  assign bus.grant_a   = ga_q;
  assign bus.grant_b   = gb_q;
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign dbg_state     = state;
endmodule

// File: doc/mux_two_arbiter.md
# mux_two_arbiter

Two-requester round-robin arbiter that shares a single 2:1 multiplexer path between requester A and requester B. It owns the mux `select` line, issues registered one-hot grants, enforces a bounded hold time so neither side starves, and registers the selected data with a valid flag. It sits directly in front of the two-input mux datapath and is the only block allowed to drive its select.

## Interface
- `WIDTH`, 1, data width of each mux input and of `out`
- `MAX_HOLD`, 4, maximum consecutive grant cycles while the other side is requesting (≥1)

- `clk`  input  1  single clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high; sampled on `clk` rising edge
- `req_a`  input  1  requester A wants the mux path
- `req_b`  input  1  requester B wants the mux path
- `a`  input  WIDTH  requester A data (mux input 0)
- `b`  input  WIDTH  requester B data (mux input 1)
- `select`  output  1  mux select; 0 = `a`, 1 = `b`
- `grant_a`  output  1  A owns the path this cycle
- `grant_b`  output  1  B owns the path this cycle
- `out`  output  WIDTH  registered mux result
- `out_valid`  output  1  `out` holds data captured under a grant

## Operation
- States: IDLE, GRANT_A, GRANT_B. `grant_a`/`grant_b` decode state (one-hot or both 0; never both 1).
- Internal `last` (1 = B last served) and hold counter `cnt` (width clog2(MAX_HOLD), min 1).
- IDLE: only `req_a` → GRANT_A; only `req_b` → GRANT_B; both → side ≠ `last`; none → stay.
- GRANT_A (GRANT_B symmetric):
  - `cnt` increments each cycle, saturates at MAX_HOLD-1.
  - `req_a`=0: go GRANT_B if `req_b`, else IDLE (no idle bubble on handover).
  - `req_a`=1, `req_b`=1, `cnt`==MAX_HOLD-1: forced switch → GRANT_B.
  - `req_a`=1 otherwise: stay.
  - On entering any grant state `cnt` clears to 0 and `last` updates to the granted side.
- `select`: 0 in GRANT_A, 1 in GRANT_B, holds previous value in IDLE.
- Datapath: every cycle `out` <= `select` ? `b` : `a`; `out_valid` <= `grant_a` | `grant_b`. In IDLE `out` still updates but `out_valid`=0.
- MAX_HOLD=1: strict alternation whenever both request.

## Timing
- Reset values: state IDLE, `grant_a`=0, `grant_b`=0, `select`=0, `out`=0, `out_valid`=0, `cnt`=0, `last`=1 (A wins the first tie).
- Reset mid-grant: all of the above at the next edge regardless of requests; reset dominates.
- Request → grant: 1 cycle (req high at edge N, grant visible after edge N+1).
- Grant → data: `a`/`b` sampled on the edge ending a grant cycle; `out`/`out_valid` valid the following cycle (1-cycle latency).
- Request drop: grant deasserts 1 cycle after `req` falls; requester must keep data valid while it sees its grant.
- Simultaneous drop of owner and rise of other: handover takes effect at the same edge (back-to-back grants).
- Forced switch occurs after exactly MAX_HOLD consecutive grant cycles with the competitor requesting; competitor waits at most MAX_HOLD+1 cycles from raising `req`.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with `req_a`=`req_b`=1 → all outputs 0, `select`=0; release → `grant_a`=1 next cycle (tie, A first).
- Single requester (WIDTH=8): `req_a`=1, `a`=8'h3C for 3 cycles → `grant_a`=1 for 3 cycles, `out`=8'h3C with `out_valid`=1 one cycle later; drop → IDLE, `out_valid`=0.
- Contention, MAX_HOLD=4: both `req` held high 12 cycles → grants A,A,A,A,B,B,B,B,A,A,A,A; `select` 0000111100 00; never both grants.
- Handover: A granted, at edge N `req_a`→0, `req_b`→1 → `grant_b`=1 at N+1, no IDLE cycle, `out`=`b` at N+2.
- Fairness: `req_b` only, drop, then both → A granted (last=B); repeat starting with A → B granted.
- Reset mid-operation: assert `reset` during GRANT_B cycle 2 → next cycle all outputs reset values, `select`=0; release with only `req_b` → `grant_b` after 1 cycle.
